bytebeat_audio_out: RTL and testbench
=====================================

Name: bytebeat_audio_out

Overview:
Output stage that sits directly downstream of the bytebeat formula core and paces it. Generates the sample-rate tick and the running time index `t` that feeds the core. Accepts each 8-bit sample over a valid/ready handshake into a one-entry buffer. Converts the current sample to a 1-bit PWM audio signal for a `uo_out` pin.

Parameters:
- SAMPLE_DIV, 1250, clk cycles per sample period (10 MHz / 1250 = 8 kHz); legal range 2..65535.
- T_WIDTH, 16, width of the time index `t_out`.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- ena  input  1  design enable; low freezes the block
- sample_in  input  8  sample from the bytebeat core
- sample_valid  input  1  sample_in is valid
- sample_ready  output  1  buffer can accept a sample
- t_out  output  T_WIDTH  time index presented to the core
- t_tick  output  1  one-cycle strobe; t_out has just advanced
- pwm_out  output  1  PWM audio bit
- underrun  output  1  sticky flag; a tick found no new sample
- clear_underrun  input  1  clears underrun

Behaviour:
- Reset (clk edge with rst_n=0) takes priority over everything and sets:
  - div_cnt=0, pwm_cnt=0, t_out=0, t_tick=0, pwm_out=0, underrun=0;
  - buf_full=0, active=8'h80, duty=8'h80 (mid-scale, no pop);
  - sample_ready=0 in the reset cycle.
- ena=0:
  - div_cnt, pwm_cnt, t_out, buffer and active are held;
  - t_tick=0, pwm_out=0, sample_ready=0;
  - underrun holds, but clear_underrun still clears it.
- Divider:
  - div_cnt counts 0..SAMPLE_DIV-1 and wraps.
  - Internal tick is asserted in the cycle where div_cnt==SAMPLE_DIV-1 and ena=1.
- Time index:
  - On the tick edge, t_out <= t_out+1 (wraps modulo 2^T_WIDTH) and t_tick <= 1 for exactly one cycle.
  - t_tick and the new t_out are therefore visible in the same cycle, one cycle after the tick.
- Handshake:
  - sample_ready = ena & ~buf_full, registered-state-derived only; there is no combinational path from sample_valid.
  - Transfer occurs when sample_valid & sample_ready at the clk edge; sample_in is latched to buf and buf_full <= 1.
  - The source may hold valid while ready is low; no data is lost or duplicated.
- Sample consumption on tick:
  - buf_full=1: active <= buf, buf_full <= 0.
  - buf_full=0 with a transfer in the same cycle: active <= sample_in directly (bypass), buf_full stays 0, no underrun.
  - buf_full=0 with no transfer: active is held (last sample repeats) and underrun <= 1.
- underrun:
  - Sticky; cleared by clear_underrun=1.
  - If set and clear happen in the same cycle, set wins.
- PWM:
  - pwm_cnt is 8 bits and increments every enabled cycle, wrapping 255->0.
  - duty <= active only on the edge where pwm_cnt==255 (frame boundary), so there are no mid-frame glitches.
  - pwm_out is registered: pwm_out <= (pwm_cnt_next < duty), i.e. high for exactly `duty` cycles of each 256-cycle frame.
  - duty=0 gives constant 0; duty=255 gives 255/256 high.
- Sample period and PWM frame are independent; a sample change takes effect at the next frame boundary (latency ≤256 cycles after active updates).
- Reset mid-operation: any buffered sample is discarded and the output returns to mid-scale duty; the source must re-present its data.

Test Plan:
- Reset then ena=1, SAMPLE_DIV=4, no samples -> t_tick pulses every 4 cycles; t_out=1,2,3...; underrun=1 after first tick; pwm_out high 128 of every 256 cycles.
- Hold sample_valid=1 with sample_in=8'h40 -> one transfer per sample period; sample_ready drops for exactly the cycles buf_full=1; no underrun; duty becomes 64 at the next frame boundary, pwm_out high 64/256.
- Present sample 8'hFF exactly on a tick cycle with buf empty -> bypass to active; underrun stays 0; later frame shows 255 high, 1 low. Sample 8'h00 -> pwm_out constant 0.
- T_WIDTH=4, run 16 ticks -> t_out wraps 15->0 with t_tick still pulsing.
- Underrun set while clear_underrun=1 in the same cycle -> underrun=1; clear alone next cycle -> 0.
- Drop ena mid-frame for 10 cycles -> pwm_out=0, sample_ready=0, counters frozen; resume continues from the same pwm_cnt/div_cnt. Assert rst_n=0 with buf_full=1 -> buffer cleared, duty=128 after reset.

Source files
------------

// File: rtl/bytebeat_audio_out.sv
// Output stage for the bytebeat core: sample-rate divider and time index,
// one-entry sample buffer on a valid/ready handshake, and an 8-bit PWM DAC.
module bytebeat_audio_out #(
    parameter int SAMPLE_DIV = 1250,
    parameter int T_WIDTH    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [7:0]         sample_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic [T_WIDTH-1:0] t_out,
    output logic               t_tick,
    output logic               pwm_out,
    output logic               underrun,
    input  logic               clear_underrun
);

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    logic [15:0]        div_cnt_q, div_cnt_d;
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic [T_WIDTH-1:0] t_q, t_d;
    logic               t_tick_q, t_tick_d;
    logic               pwm_q, pwm_d;
    logic               underrun_q, underrun_d;
    logic [7:0]         buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic [7:0]         active_q, active_d;
    logic [7:0]         duty_q, duty_d;
    logic               tick;
    logic               xfer;

    // rst_n is included so no transfer is advertised during the reset cycle.
    assign sample_ready = ena & rst_n & ~buf_full_q;
    assign xfer         = sample_valid & sample_ready;
    assign tick         = ena & (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d  = div_cnt_q;
        pwm_cnt_d  = pwm_cnt_q;
        t_d        = t_q;
        t_tick_d   = tick;
        pwm_d      = 1'b0;
        underrun_d = underrun_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        active_d   = active_q;
        duty_d     = duty_q;

        if (ena) begin
            div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
            // Duty only reloads at the frame wrap so a frame never glitches.
            if (pwm_cnt_q == 8'hFF) begin
                duty_d = active_q;
            end
            pwm_d = (pwm_cnt_d < duty_d);
        end

        if (tick) begin
            t_d = t_q + 1'b1;
        end

        if (tick) begin
            if (buf_full_q) begin
                active_d   = buf_q;
                buf_full_d = 1'b0;
            end else if (xfer) begin
                active_d = sample_in;
            end
        end else if (xfer) begin
            buf_d      = sample_in;
            buf_full_d = 1'b1;
        end

        if (tick && !buf_full_q && !xfer) begin
            underrun_d = 1'b1;
        end else if (clear_underrun) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            t_q        <= '0;
            t_tick_q   <= 1'b0;
            pwm_q      <= 1'b0;
            underrun_q <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            active_q   <= 8'h80;
            duty_q     <= 8'h80;
        end else begin
            div_cnt_q  <= div_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            t_q        <= t_d;
            t_tick_q   <= t_tick_d;
            pwm_q      <= pwm_d;
            underrun_q <= underrun_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            active_q   <= active_d;
            duty_q     <= duty_d;
        end
    end

    assign t_out    = t_q;
    assign t_tick   = t_tick_q;
    assign pwm_out  = pwm_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_bytebeat_audio_out.sv
// Bench for bytebeat_audio_out: directed vector table, PWM duty windows,
// corner sequences and a randomized run against a behavioural model.
module tb_bytebeat_audio_out;

    localparam int DIV = 4;
    localparam int TW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic [7:0]    sample_in = 8'h00;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic [TW-1:0] t_out;
    logic          t_tick;
    logic          pwm_out;
    logic          underrun;
    logic          clear_underrun = 1'b0;

    always #5 clk = ~clk;

    bytebeat_audio_out #(.SAMPLE_DIV(DIV), .T_WIDTH(TW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .t_out         (t_out),
        .t_tick        (t_tick),
        .pwm_out       (pwm_out),
        .underrun      (underrun),
        .clear_underrun(clear_underrun)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_ready = 0;

    // Behavioural model: sample period counter, queue of at most one sample,
    // position in the 256-cycle PWM frame.
    int m_div, m_t, m_tick, m_active, m_duty, m_pos, m_pwm, m_un;
    int m_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int m_ready(input bit r, input bit e);
        return (r && e && m_q.size() == 0) ? 1 : 0;
    endfunction

    task automatic model_update(input bit r, input bit e, input logic [7:0] s,
                                input bit c, input bit xfer);
        bit tick_now;
        bit empty;
        int old_active;
        if (!r) begin
            m_div = 0; m_pos = 0; m_t = 0; m_tick = 0; m_pwm = 0; m_un = 0;
            m_q.delete();
            m_active = 128; m_duty = 128;
            return;
        end
        tick_now   = e && (m_div == DIV - 1);
        empty      = (m_q.size() == 0);
        old_active = m_active;
        if (e) m_div = (m_div + 1) % DIV;
        m_tick = tick_now ? 1 : 0;
        if (tick_now) m_t = (m_t + 1) % (1 << TW);
        if (tick_now && empty && !xfer) m_un = 1;
        else if (c) m_un = 0;
        if (tick_now) begin
            if (!empty) m_active = m_q.pop_front();
            else if (xfer) m_active = int'(s);
        end else if (xfer) begin
            m_q.push_back(int'(s));
        end
        if (e) begin
            if (m_pos == 255) m_duty = old_active;
            m_pos = (m_pos + 1) % 256;
            m_pwm = (m_pos < m_duty) ? 1 : 0;
        end else begin
            m_pwm = 0;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit v,
                        input logic [7:0] s, input bit c);
        bit xfer;
        rst_n = r; ena = e; sample_valid = v; sample_in = s; clear_underrun = c;
        @(negedge clk);
        last_ready = int'(sample_ready);
        chk("sample_ready", last_ready, m_ready(r, e));
        xfer = v && (m_ready(r, e) != 0);
        @(posedge clk);
        #1;
        model_update(r, e, s, c, xfer);
        cyc++;
        chk("t_out", int'(t_out), m_t);
        chk("t_tick", int'(t_tick), m_tick);
        chk("pwm_out", int'(pwm_out), m_pwm);
        chk("underrun", int'(underrun), m_un);
    endtask

    // Warm up with a steady input, then count high cycles over one full frame.
    task automatic count_pwm(input bit v, input logic [7:0] s, output int hi);
        hi = 0;
        for (int i = 0; i < 600; i++) step(1, 1, v, s, (i == 0));
        for (int i = 0; i < 256; i++) begin
            step(1, 1, v, s, 0);
            hi += int'(pwm_out);
        end
    endtask

    typedef struct {
        bit         e;
        bit         v;
        logic [7:0] s;
        bit         c;
        int         rdy;
        int         t;
        int         tk;
        int         un;
    } vec_t;

    vec_t tbl[21];

    initial begin
        int hi;
        int t_before;
        int found;

        tbl[0]  = '{1, 0, 8'h00, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 8'h00, 0, 1, 0, 0, 0};
        tbl[2]  = '{1, 0, 8'h00, 0, 1, 0, 0, 0};
        tbl[3]  = '{1, 0, 8'h00, 0, 1, 1, 1, 1};
        tbl[4]  = '{1, 1, 8'h40, 1, 1, 1, 0, 0};
        tbl[5]  = '{1, 0, 8'h00, 0, 0, 1, 0, 0};
        tbl[6]  = '{1, 0, 8'h00, 0, 0, 1, 0, 0};
        tbl[7]  = '{1, 0, 8'h00, 0, 0, 2, 1, 0};
        tbl[8]  = '{1, 0, 8'h00, 0, 1, 2, 0, 0};
        tbl[9]  = '{1, 0, 8'h00, 0, 1, 2, 0, 0};
        tbl[10] = '{1, 0, 8'h00, 0, 1, 2, 0, 0};
        tbl[11] = '{1, 1, 8'hFF, 0, 1, 3, 1, 0};
        tbl[12] = '{1, 0, 8'h00, 0, 1, 3, 0, 0};
        tbl[13] = '{1, 0, 8'h00, 0, 1, 3, 0, 0};
        tbl[14] = '{1, 0, 8'h00, 0, 1, 3, 0, 0};
        tbl[15] = '{1, 0, 8'h00, 1, 1, 4, 1, 1};
        tbl[16] = '{1, 0, 8'h00, 1, 1, 4, 0, 0};
        tbl[17] = '{0, 1, 8'h55, 0, 0, 4, 0, 0};
        tbl[18] = '{1, 0, 8'h00, 0, 1, 4, 0, 0};
        tbl[19] = '{1, 0, 8'h00, 0, 1, 4, 0, 0};
        tbl[20] = '{1, 0, 8'h00, 0, 1, 5, 1, 1};

        // Reset with ena high: ready must stay low in the reset cycle.
        m_q.delete();
        step(0, 1, 1, 8'h12, 0);
        chk("reset_ready", last_ready, 0);
        step(0, 1, 0, 8'h00, 0);
        chk("reset_t_out", int'(t_out), 0);
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_underrun", int'(underrun), 0);

        for (int i = 0; i < 21; i++) begin
            step(1, tbl[i].e, tbl[i].v, tbl[i].s, tbl[i].c);
            chk($sformatf("vec%0d_ready", i), last_ready, tbl[i].rdy);
            chk($sformatf("vec%0d_t_out", i), int'(t_out), tbl[i].t);
            chk($sformatf("vec%0d_t_tick", i), int'(t_tick), tbl[i].tk);
            chk($sformatf("vec%0d_underrun", i), int'(underrun), tbl[i].un);
        end

        // Continuous 0x40 source: no underrun, quarter duty.
        count_pwm(1, 8'h40, hi);
        chk("duty_40_high", hi, 64);
        chk("duty_40_underrun", int'(underrun), 0);

        // Present 0xFF exactly on a tick cycle with the buffer empty.
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (m_div == DIV - 1 && m_q.size() == 0) found = 1;
            else step(1, 1, 0, 8'h00, 0);
        end
        chk("bypass_slot_found", found, 1);
        step(1, 1, 1, 8'hFF, 0);
        chk("bypass_underrun", int'(underrun), 0);
        chk("bypass_ready", int'(sample_ready), 1);
        count_pwm(0, 8'h00, hi);
        chk("duty_ff_high", hi, 255);

        count_pwm(1, 8'h00, hi);
        chk("duty_00_high", hi, 0);

        // Freeze for 10 cycles mid-frame, then resume.
        for (int i = 0; i < 37; i++) step(1, 1, 1, 8'h80, 0);
        t_before = int'(t_out);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 8'h33, 0);
            chk("freeze_pwm", int'(pwm_out), 0);
            chk("freeze_ready", last_ready, 0);
            chk("freeze_t_out", int'(t_out), t_before);
        end
        for (int i = 0; i < 20; i++) step(1, 1, 1, 8'h80, 0);

        // Load the buffer, then reset: the buffered sample must be lost.
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step(1, 1, (m_div != DIV - 1), 8'h10, 0);
            if (m_q.size() == 1) found = 1;
        end
        chk("buffer_loaded", found, 1);
        chk("buffer_full_ready", int'(sample_ready), 0);
        step(0, 1, 0, 8'h00, 0);
        chk("rst_mid_ready", int'(sample_ready), 0);
        chk("rst_mid_t_out", int'(t_out), 0);
        count_pwm(0, 8'h00, hi);
        chk("rst_mid_duty", hi, 128);
        chk("rst_mid_underrun", int'(underrun), 1);

        // Randomized traffic, occasional resets and enable drops.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
